if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, issues single-outstanding requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register whose `id_pc`/`id_instr` feed the ID-stage decoder. Supports hazard-unit stall, pipeline flush and branch/jump redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0000, bubble instruction (decodes as `sll $0,$0,0`)

- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `stall`  in  1  hazard unit: hold IF/ID contents
- `flush`  in  1  squash IF/ID and any instruction loading this cycle
- `redirect_en`  in  1  taken branch/jump
- `redirect_pc`  in  32  target; bits [1:0] ignored (forced 0)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word-aligned, stable while `imem_req`=1
- `imem_ack`  in  1  data valid; may arrive in the same cycle as `imem_req`
- `imem_rdata`  in  32  fetched instruction, valid when `imem_ack`=1
- `id_pc`  out  32  IF/ID: address of `id_instr`
- `id_instr`  out  32  IF/ID: instruction to decode
- `id_valid`  out  1  IF/ID: 1 = real instruction, 0 = bubble

## Operation
- Registers: `req_addr` (drives `imem_addr`), `tgt_pc` (pending redirect target), skid buffer {`buf_pc`,`buf_instr`}, IF/ID {`id_pc`,`id_instr`,`id_valid`}, state.
- States: BOOT, FETCH, HELD, DRAIN.
- BOOT: `imem_req`=0; next cycle → FETCH.
- FETCH: `imem_req`=1. No ack: IF/ID loads bubble unless `stall` (hold). Ack & !stall: IF/ID ← {`req_addr`,`imem_rdata`,1}; `req_addr`+=4; stay. Ack & stall: buffer ← {`req_addr`,`imem_rdata`}; `req_addr`+=4; → HELD.
- HELD: `imem_req`=0. When !stall: IF/ID ← buffer with valid=1; → FETCH.
- DRAIN: `imem_req`=1, `imem_addr` = old `req_addr`; on ack discard data, `req_addr` ← `tgt_pc`, → FETCH; IF/ID loads bubble unless `stall`.
- Redirect (priority over all except reset): in FETCH without ack → `tgt_pc` ← target, → DRAIN. In FETCH with ack, or in HELD/BOOT → data/buffer discarded, `req_addr` ← target, → FETCH. In DRAIN → `tgt_pc` overwritten (latest wins).
- Flush: IF/ID ← {0,`NOP_INSTR`,0} regardless of `stall`; discards ack data arriving that cycle and HELD buffer (HELD → FETCH). Does not change `req_addr`.
- Stall never blocks the handshake; at most one instruction is buffered.
- Arithmetic: `req_addr`+4 modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset values: state BOOT, `req_addr`=`RESET_PC`, `tgt_pc`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `id_pc`=0, `id_instr`=`NOP_INSTR`, `id_valid`=0.
- Reset deassert → 1 BOOT cycle → `imem_req`=1 at `RESET_PC`.
- Latency: ack in cycle N → `id_instr` valid after edge ending N. Zero-wait memory → 1 instr/cycle.
- Redirect in cycle N with ack or no outstanding request → `imem_addr`=target in N+1.
- Reset mid-request: state returns to BOOT immediately; late ack in BOOT ignored.

## Structure
- Shared package: `NOP_INSTR`, `PC_INCR`=4, state encoding, IF/ID bundle widths.
- Sub-module `if_id_reg`: IF/ID register with load/stall/flush (flush > stall > load).

## Test plan
- Reset, zero-wait memory returning `addr`^32'hA5A5_A5A5 → `id_pc` 0,4,8… on consecutive cycles, `id_valid`=1 from first ack.
- 2-wait-state memory → each instruction followed by 2 bubbles (`id_valid`=0, `id_instr`=0).
- `stall` 3 cycles while ack arrives for 0x10 → IF/ID holds 0x0C, 0x10 buffered, `imem_req`=0, then 0x10 delivered after release, fetch resumes at 0x14.
- Redirect to 0x400 while request 0x20 outstanding → `imem_addr` stays 0x20 until ack, 0x20 data never reaches ID, next request 0x400.
- `flush`+redirect to 0x80 with same-cycle ack → IF/ID bubble, next `id_pc`=0x80.
- `RESET_PC`=32'hFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage:
// bubble encoding, PC step, FSM states and the IF/ID bundle.
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  localparam if_id_t IF_ID_BUBBLE = '{
    pc:    '0,
    instr: NOP_INSTR,
    valid: 1'b0
  };

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush > stall > load; idle cycles insert a bubble.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_instr,
  output if_id_t          q
);

  // Bubble on flush or idle, hold on stall, capture on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_BUBBLE;
    end else if (flush) begin
      q <= IF_ID_BUBBLE;
    end else if (stall) begin
      q <= q;
    end else if (load) begin
      q <= '{pc: d_pc, instr: d_instr, valid: 1'b1};
    end else begin
      q <= IF_ID_BUBBLE;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem
// handshake, one-entry skid buffer and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid
);

  fetch_state_t    state;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_addr;

  logic            ld;
  logic [XLEN-1:0] ld_pc;
  logic [XLEN-1:0] ld_instr;
  if_id_t          if_id;

  assign target    = word_align(redirect_pc);
  assign next_addr = req_addr + PC_INCR;

  // Request is raised whenever a fetch is in flight,
  // including the squashed one being drained.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = req_addr;

  // Choose what the IF/ID register captures this cycle.
  always_comb begin
    ld       = 1'b0;
    ld_pc    = buf_pc;
    ld_instr = buf_instr;
    unique case (1'b1)
      state == FETCH: begin
        ld       = imem_ack && !redirect_en;
        ld_pc    = req_addr;
        ld_instr = imem_rdata;
      end
      state == HELD: begin
        ld = !redirect_en;
      end
      default: begin
        ld = 1'b0;
      end
    endcase
  end

  // Fetch FSM: address sequencing, redirect and skid capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      req_addr  <= RESET_PC;
      tgt_pc    <= '0;
      buf_pc    <= '0;
      buf_instr <= NOP_INSTR;
    end else begin
      unique case (state)
        BOOT: begin
          state <= FETCH;
          if (redirect_en) req_addr <= target;
        end
        FETCH: begin
          if (redirect_en) begin
            if (imem_ack) begin
              req_addr <= target;
            end else begin
              tgt_pc <= target;
              state  <= DRAIN;
            end
          end else if (imem_ack) begin
            req_addr <= next_addr;
            if (stall && !flush) begin
              buf_pc    <= req_addr;
              buf_instr <= imem_rdata;
              state     <= HELD;
            end
          end
        end
        HELD: begin
          if (redirect_en) begin
            req_addr <= target;
            state    <= FETCH;
          end else if (flush || !stall) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_en) tgt_pc <= target;
          if (imem_ack) begin
            req_addr <= redirect_en ? target : tgt_pc;
            state    <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .stall   (stall),
    .flush   (flush),
    .d_pc    (ld_pc),
    .d_instr (ld_instr),
    .q       (if_id)
  );

  assign id_pc    = if_id.pc;
  assign id_instr = if_id.instr;
  assign id_valid = if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a
// transaction-level fetch model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;
  logic        sel = 1'b0;

  logic        req_a, req_b, val_a, val_b;
  logic [31:0] addr_a, addr_b, pc_a, pc_b, ins_a, ins_b;
  logic        ack_a, ack_b;

  logic        o_req, o_val;
  logic [31:0] o_addr, o_pc, o_ins;

  assign ack_a  = sel ? 1'b0 : ack;
  assign ack_b  = sel ? ack : 1'b0;
  assign o_req  = sel ? req_b  : req_a;
  assign o_addr = sel ? addr_b : addr_a;
  assign o_pc   = sel ? pc_b   : pc_a;
  assign o_ins  = sel ? ins_b  : ins_a;
  assign o_val  = sel ? val_b  : val_a;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(req_a), .imem_addr(addr_a),
    .imem_ack(ack_a), .imem_rdata(rdata),
    .id_pc(pc_a), .id_instr(ins_a), .id_valid(val_a)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(ack_b), .imem_rdata(rdata),
    .id_pc(pc_b), .id_instr(ins_b), .id_valid(val_b)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: what the fetch unit owes the pipeline.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [31:0] m_rpc;
  logic        m_boot;
  logic        m_req;
  logic [31:0] m_addr;
  ent_t        m_skid[$];
  logic        m_drop;
  logic [31:0] m_tgt;
  logic        m_val;
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  int          wcnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_req  = 1'b0;
    m_addr = m_rpc;
    m_skid.delete();
    m_drop = 1'b0;
    m_tgt  = '0;
    m_val  = 1'b0;
    m_pc   = '0;
    m_ins  = NOP_INSTR;
    wcnt   = -1;
  endtask

  task automatic model_step(input bit s, input bit f,
                            input bit r, input logic [31:0] t,
                            input bit a, input logic [31:0] d);
    bit   del;
    ent_t e;
    del = 0;
    e.pc = '0;
    e.instr = '0;
    if (m_boot) begin
      m_boot = 0;
      m_req  = 1;
      if (r) m_addr = t;
    end else if (m_skid.size() != 0) begin
      if (r) begin
        m_skid.delete();
        m_addr = t;
        m_req  = 1;
      end else if (f) begin
        m_skid.delete();
        m_req = 1;
      end else if (!s) begin
        e = m_skid.pop_front();
        del = 1;
        m_req = 1;
      end
    end else if (m_drop) begin
      if (r) m_tgt = t;
      if (a) begin
        m_drop = 0;
        m_addr = m_tgt;
      end
    end else begin
      if (a) begin
        e.pc = m_addr;
        e.instr = d;
        if (r) begin
          m_addr = t;
        end else begin
          m_addr = m_addr + 32'd4;
          if (f) begin
          end else if (s) begin
            m_skid.push_back(e);
            m_req = 0;
          end else begin
            del = 1;
          end
        end
      end else if (r) begin
        m_drop = 1;
        m_tgt  = t;
      end
    end
    if (f) begin
      m_val = 0; m_pc = '0; m_ins = NOP_INSTR;
    end else if (s) begin
    end else if (del) begin
      m_val = 1; m_pc = e.pc; m_ins = e.instr;
    end else begin
      m_val = 0; m_pc = '0; m_ins = NOP_INSTR;
    end
  endtask

  task automatic check_outputs();
    check("imem_req", {31'd0, o_req}, {31'd0, m_req});
    check("imem_addr", o_addr, m_addr);
    check("id_valid", {31'd0, o_val}, {31'd0, m_val});
    check("id_pc", o_pc, m_pc);
    check("id_instr", o_ins, m_ins);
  endtask

  task automatic do_reset();
    @(negedge clk);
    stall = 0; flush = 0; redirect_en = 0; ack = 0;
    rst = 1;
    #1;
    check("rst_req", {31'd0, o_req}, 32'd0);
    check("rst_addr", o_addr, m_rpc);
    check("rst_valid", {31'd0, o_val}, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_instr", o_ins, NOP_INSTR);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // One cycle: compare, drive, advance the model.
  task automatic cycle(input int lmin, input int lmax,
                       input int ps, input int pf,
                       input int pr, input bit boot_ack);
    logic [31:0] t;
    bit a;
    check_outputs();
    stall = ($urandom_range(99) < ps);
    flush = ($urandom_range(99) < pf);
    redirect_en = ($urandom_range(99) < pr);
    if ($urandom_range(9) == 0)
      redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else
      redirect_pc = $urandom_range(0, 1023);
    t = word_align(redirect_pc);
    a = 0;
    if (m_req) begin
      if (wcnt < 0) wcnt = $urandom_range(lmax, lmin);
      a = (wcnt == 0);
      wcnt = a ? -1 : wcnt - 1;
    end else begin
      wcnt = -1;
      if (m_boot && boot_ack) a = $urandom_range(1);
    end
    ack = a;
    rdata = a ? (m_req ? mem_word(m_addr) : $urandom) : 32'hDEAD_BEEF;
    model_step(stall, flush, redirect_en, t, a, rdata);
    @(negedge clk);
  endtask

  initial begin
    sel = 0;
    m_rpc = 32'h0000_0000;
    model_reset();
    do_reset();
    repeat (20) cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (30) cycle(2, 2, 0, 0, 0, 0);
    do_reset();
    repeat (60) cycle(0, 1, 30, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      do_reset();
      repeat ($urandom_range(300, 50))
        cycle(0, 3, 25, 6, 10, 1);
    end
    do_reset();
    repeat (400) cycle(0, 2, 40, 10, 20, 1);
    sel = 1;
    m_rpc = 32'hFFFF_FFF8;
    do_reset();
    repeat (8) cycle(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (300) cycle(0, 2, 25, 5, 10, 1);
    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
